alu_result_fifo: RTL and testbench

//  Output-side buffer directly downstream of the ALU DUT. Captures each ALU result with its

---
 rtl/alu_result_fifo.sv | 95 +++++++++
 tb/tb_alu_result_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO capturing ALU result/tag pairs, handing them to a
// valid/ready consumer and accounting for results lost when the buffer is full.
module alu_result_fifo #(
   parameter int DEPTH  = 4,
   parameter int RES_W  = 16,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [RES_W-1:0]         in_result,
   input  logic [ADDR_W-1:0]        in_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [RES_W-1:0]         out_result,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt,
   input  logic                     clr_ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [RES_W-1:0]  mem_res  [DEPTH];
   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [OCC_W-1:0]  occ;

   logic pop;
   logic push_ok;
   logic drop;

   // Handshake decode; a full FIFO still takes a push when the head leaves the same cycle.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
      pop     = out_valid & out_ready;
      push_ok = in_valid & (~full | pop);
      drop    = in_valid & full & ~pop;
   end

   // Occupancy-derived status and show-ahead head, all from registered state only.
   assign count      = occ;
   assign out_valid  = (occ != '0);
   assign full       = (occ == OCC_W'(DEPTH));
   assign out_result = out_valid ? mem_res[rd_ptr]  : '0;
   assign out_addr   = out_valid ? mem_addr[rd_ptr] : '0;

   // Storage write; contents are qualified by occupancy so they are left unreset.
   always_ff @(posedge clk) begin
      // NOTE: the data array has no reset - out_valid gates its use, and a reset would only cost flops.
      if (push_ok) begin
         mem_res[wr_ptr]  <= in_result;
         mem_addr[wr_ptr] <= in_addr;
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Overflow bookkeeping; a drop in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf)         drop_cnt <= CNT_W'(1);
         else if (!(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the FIFO and its drop accounting.
module tb_alu_result_fifo;

   localparam int DEPTH  = 4;
   localparam int RES_W  = 16;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 8;

   typedef struct {
      logic [RES_W-1:0]  res;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              in_valid;
   logic [RES_W-1:0]  in_result;
   logic [ADDR_W-1:0] in_addr;
   logic              out_valid;
   logic              out_ready;
   logic [RES_W-1:0]  out_result;
   logic [ADDR_W-1:0] out_addr;
   logic [2:0]        count;
   logic              full;
   logic              overflow;
   logic [CNT_W-1:0]  drop_cnt;
   logic              clr_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   entry_t     q[$];
   logic       m_ovf;
   int         m_drops;

   alu_result_fifo #(.DEPTH(DEPTH), .RES_W(RES_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_result  (in_result),
      .in_addr    (in_addr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_addr   (out_addr),
      .count      (count),
      .full       (full),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .clr_ovf    (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compare every output against the model's current view.
   task automatic check_outputs(input string tag);
      int sz;
      sz = q.size();
      check({tag, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
      check({tag, ".count"},     32'(count),     32'(sz));
      check({tag, ".full"},      32'(full),      32'(sz == DEPTH));
      check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
      check({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drops));
      check({tag, ".out_result"}, 32'(out_result), (sz != 0) ? 32'(q[0].res)  : 32'd0);
      check({tag, ".out_addr"},   32'(out_addr),   (sz != 0) ? 32'(q[0].addr) : 32'd0);
   endtask

   // Apply one cycle of stimulus: check outputs before the edge, then advance the model.
   task automatic cycle(input string tag, input logic v, input logic [RES_W-1:0] r,
                        input logic [ADDR_W-1:0] a, input logic rdy, input logic clr);
      logic   do_pop;
      entry_t e;
      in_valid  = v;
      in_result = r;
      in_addr   = a;
      out_ready = rdy;
      clr_ovf   = clr;
      @(negedge clk);
      check_outputs(tag);
      do_pop = (q.size() != 0) && rdy;
      if (v && q.size() == DEPTH && !do_pop) begin
         m_ovf   = 1'b1;
         m_drops = clr ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
      end else begin
         if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
         end
         if (do_pop) void'(q.pop_front());
         if (v) begin
            e.res  = r;
            e.addr = a;
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_addr   = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single push, head held while consumer stalls
      cycle("t1.push", 1'b1, 16'h1234, 8'h05, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle("t1.hold", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      check("t1.head_result", 32'(out_result), 32'h1234);
      cycle("t1.drain", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      // 2: fill, overflow on fifth push, drain in order
      for (int i = 1; i <= 4; i++) cycle("t2.fill", 1'b1, 16'(i * 16'h111), 8'(i), 1'b0, 1'b0);
      check("t2.full", 32'(full), 32'd1);
      cycle("t2.drop", 1'b1, 16'hdead, 8'd5, 1'b0, 1'b0);
      check("t2.drop_cnt", 32'(drop_cnt), 32'd1);
      for (int i = 0; i < 5; i++) cycle("t2.drain", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      cycle("t2.clr", 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

      // 3: push into a full FIFO while popping
      for (int i = 1; i <= 4; i++) cycle("t3.fill", 1'b1, 16'(i), 8'(i), 1'b0, 1'b0);
      cycle("t3.pushpop", 1'b1, 16'h0909, 8'd9, 1'b1, 1'b0);
      check("t3.overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 5; i++) cycle("t3.drain", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      // 4: streaming push+pop, pointers wrap repeatedly
      for (int i = 0; i < 10; i++) cycle("t4.stream", 1'b1, 16'(16'hA000 + i), 8'(i), 1'b1, 1'b0);
      cycle("t4.drain", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      // 5: saturating drop counter, clear-vs-drop priority
      for (int i = 0; i < 4; i++) cycle("t5.fill", 1'b1, 16'(i), 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 260; i++) cycle("t5.drop", 1'b1, 16'hffff, 8'hff, 1'b0, 1'b0);
      check("t5.sat", 32'(drop_cnt), 32'd255);
      cycle("t5.clr_drop", 1'b1, 16'hffff, 8'hff, 1'b0, 1'b1);
      cycle("t5.clr_only", 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
      cycle("t5.after", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      check("t5.cleared", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < 4; i++) cycle("t5.drain", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      // 6: asynchronous reset mid-stream with entries held and overflow set
      for (int i = 0; i < 3; i++) cycle("t6.fill", 1'b1, 16'(i + 16'h60), 8'(i + 8'h60), 1'b0, 1'b0);
      cycle("t6.fill4", 1'b1, 16'h64, 8'h64, 1'b0, 1'b0);
      cycle("t6.drop", 1'b1, 16'h65, 8'h65, 1'b0, 1'b0);
      cycle("t6.pop1", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("t6.async_valid", 32'(out_valid), 32'd0);
      check("t6.async_count", 32'(count), 32'd0);
      check("t6.async_ovf",   32'(overflow), 32'd0);
      check_outputs("t6.async");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cycle("t6.push7", 1'b1, 16'h0777, 8'd7, 1'b0, 1'b0);
      check("t6.head_addr", 32'(out_addr), 32'd7);
      cycle("t6.drain", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle("rand",
               1'($urandom_range(0, 99) < 60),
               16'($urandom()),
               8'($urandom()),
               1'($urandom_range(0, 99) < 45),
               1'($urandom_range(0, 99) < 5));
      end

      @(negedge clk);
      check_outputs("final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
